// File: rtl/out_display_pkg.sv
// Shared types and constants for the scanned 7-segment output display.
package out_display_pkg;

    // Segment patterns for hex digits 0..F (bit0=a .. bit6=g, bit7=dp).
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DASH  = 8'h40;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT1 = 3'd2,
        ST_SHIFT2 = 3'd3,
        ST_COMMIT = 3'd4
    } state_e;

    // Five BCD digits of a 16-bit value; index 0 is the units digit.
    typedef logic [4:0][3:0] bcd5_t;

endpackage

// File: rtl/out_scan_display_bcd.sv
// 16-bit sequential double-dabble converter. The start cycle performs the
// first shift step on bin_i directly, so results are ready after 16 edges.
module bin_to_bcd_seq
    import out_display_pkg::*;
(
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [15:0] bin_i,
    output bcd5_t       bcd_o,
    output logic        done_o
);

    logic [35:0] sr_q;
    logic [3:0]  left_q;
    logic        done_q;
    logic [35:0] step_s;

    // One double-dabble iteration: add 3 to every digit >= 5, then shift left.
    function automatic logic [35:0] dd_step(input logic [35:0] v);
        logic [35:0] t;
        t = v;
        for (int d = 0; d < 5; d++) begin
            if (t[16 + 4*d +: 4] >= 4'd5) begin
                t[16 + 4*d +: 4] = t[16 + 4*d +: 4] + 4'd3;
            end else begin
                t[16 + 4*d +: 4] = t[16 + 4*d +: 4];
            end
        end
        return {t[34:0], 1'b0};
    endfunction

    // Next shift-register value, seeded from bin_i on a start pulse.
    always_comb begin
        step_s = '0;
        if (start_i) begin
            step_s = dd_step({20'd0, bin_i});
        end else begin
            step_s = dd_step(sr_q);
        end
    end

    // Shift register, remaining-step counter and done flag.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sr_q   <= 36'd0;
            left_q <= 4'd0;
            done_q <= 1'b0;
        end else if (start_i) begin
            sr_q   <= step_s;
            left_q <= 4'd15;
            done_q <= 1'b0;
        end else if (left_q != 4'd0) begin
            sr_q   <= step_s;
            left_q <= left_q - 4'd1;
            done_q <= (left_q == 4'd1);
        end else begin
            sr_q   <= sr_q;
            left_q <= left_q;
            done_q <= done_q;
        end
    end

    assign bcd_o  = sr_q[35:16];
    assign done_o = done_q;

endmodule

// File: rtl/out_scan_display.sv
// Slot-based processor output display: stores value pairs, renders the paged
// slot in hex or blanked decimal, and scans it onto a 7-segment bank.
module out_scan_display
    import out_display_pkg::*;
#(
    parameter int NUM_SLOTS  = 8,
    parameter int SEL_W      = 3,
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 4000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [SEL_W-1:0]      wr_sel,
    input  logic [15:0]           wr_val1,
    input  logic [15:0]           wr_val2,
    input  logic                  wr_dec,
    input  logic [SEL_W-1:0]      page,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] seg_sel,
    output logic                  busy
);

    localparam int D     = NUM_DIGITS / 2;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [SEL_W:0] NUM_SLOTS_W = (SEL_W+1)'(NUM_SLOTS);

    logic [15:0] slot_val1_q [NUM_SLOTS];
    logic [15:0] slot_val2_q [NUM_SLOTS];
    logic        slot_dec_q  [NUM_SLOTS];

    state_e                     state_q;
    logic                       dirty_q;
    logic                       busy_q;
    logic [3:0]                 cnt_q;
    logic [SEL_W-1:0]           page_prev_q;
    logic [15:0]                snap_val1_q;
    logic [15:0]                snap_val2_q;
    logic                       snap_dec_q;
    logic                       snap_valid_q;
    bcd5_t                      bcd1_q;
    logic [NUM_DIGITS-1:0][7:0] buf_q;

    logic [CNT_W-1:0]           scan_cnt_q;
    logic [IDX_W-1:0]           idx_q;
    logic [7:0]                 seg_q;
    logic [NUM_DIGITS-1:0]      seg_sel_q;

    logic                       wr_ok_s;
    logic                       page_ok_s;
    logic                       trigger_s;
    logic                       conv_start_s;
    bcd5_t                      conv_bcd_s;
    logic                       conv_done_s;
    logic [NUM_DIGITS-1:0][7:0] render_s;
    logic [19:0]                val_ext_s;
    bcd5_t                      bcd_s;
    logic                       ovf_s;
    logic                       lead_s;
    logic [7:0]                 digit_s;

    assign wr_ok_s      = ({1'b0, wr_sel} < NUM_SLOTS_W);
    assign page_ok_s    = ({1'b0, page} < NUM_SLOTS_W);
    assign trigger_s    = (wr_en && (wr_sel == page)) || (page != page_prev_q);
    assign conv_start_s = ((state_q == ST_SHIFT1) || (state_q == ST_SHIFT2)) && (cnt_q == 4'd0);

    bin_to_bcd_seq u_bcd (
        .clock_i (clock),
        .reset_i (reset),
        .start_i (conv_start_s),
        .bin_i   ((state_q == ST_SHIFT2) ? snap_val2_q : snap_val1_q),
        .bcd_o   (conv_bcd_s),
        .done_o  (conv_done_s)
    );

    // Slot storage written by the processor; out-of-range selects are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_val1_q[i] <= 16'd0;
                slot_val2_q[i] <= 16'd0;
                slot_dec_q[i]  <= 1'b0;
            end
        end else if (wr_en && wr_ok_s) begin
            slot_val1_q[wr_sel] <= wr_val1;
            slot_val2_q[wr_sel] <= wr_val2;
            slot_dec_q[wr_sel]  <= wr_dec;
        end
    end

    // Render the snapshot into segment codes; upper half = val1, lower = val2.
    always_comb begin
        render_s  = '0;
        val_ext_s = 20'd0;
        bcd_s     = '0;
        ovf_s     = 1'b0;
        lead_s    = 1'b1;
        digit_s   = SEG_BLANK;
        for (int h = 0; h < 2; h++) begin
            val_ext_s = (h == 1) ? {4'h0, snap_val1_q} : {4'h0, snap_val2_q};
            bcd_s     = (h == 1) ? bcd1_q : conv_bcd_s;
            ovf_s     = 1'b0;
            for (int j = 0; j < 5; j++) begin
                if ((j >= D) && (bcd_s[j] != 4'h0)) begin
                    ovf_s = 1'b1;
                end else begin
                    ovf_s = ovf_s;
                end
            end
            lead_s = 1'b1;
            for (int i = D - 1; i >= 0; i--) begin
                if (bcd_s[i] != 4'h0) begin
                    lead_s = 1'b0;
                end else begin
                    lead_s = lead_s;
                end
                if (!snap_valid_q) begin
                    digit_s = SEG_BLANK;
                end else if (!snap_dec_q) begin
                    digit_s = SEG_TABLE[val_ext_s[4*i +: 4]];
                end else if (ovf_s) begin
                    digit_s = SEG_DASH;
                end else if (lead_s && (i != 0)) begin
                    digit_s = SEG_BLANK;
                end else begin
                    digit_s = SEG_TABLE[bcd_s[i]];
                end
                render_s[h*D + i] = digit_s;
            end
        end
    end

    // Conversion FSM: dirty tracking, snapshot, BCD sequencing and buffer commit.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            dirty_q      <= 1'b1;
            busy_q       <= 1'b0;
            cnt_q        <= 4'd0;
            page_prev_q  <= page;
            snap_val1_q  <= 16'd0;
            snap_val2_q  <= 16'd0;
            snap_dec_q   <= 1'b0;
            snap_valid_q <= 1'b0;
            bcd1_q       <= '0;
            buf_q        <= '0;
        end else begin
            page_prev_q <= page;
            case (state_q)
                ST_IDLE: begin
                    dirty_q <= trigger_s;
                    if (dirty_q) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    dirty_q      <= dirty_q | trigger_s;
                    snap_valid_q <= page_ok_s;
                    snap_val1_q  <= page_ok_s ? slot_val1_q[page] : 16'd0;
                    snap_val2_q  <= page_ok_s ? slot_val2_q[page] : 16'd0;
                    snap_dec_q   <= page_ok_s ? slot_dec_q[page]  : 1'b0;
                    cnt_q        <= 4'd0;
                    if (page_ok_s && slot_dec_q[page]) begin
                        state_q <= ST_SHIFT1;
                    end else begin
                        state_q <= ST_COMMIT;
                    end
                end
                ST_SHIFT1: begin
                    dirty_q <= dirty_q | trigger_s;
                    cnt_q   <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_q <= ST_SHIFT2;
                    end else begin
                        state_q <= ST_SHIFT1;
                    end
                end
                ST_SHIFT2: begin
                    dirty_q <= dirty_q | trigger_s;
                    cnt_q   <= cnt_q + 4'd1;
                    if ((cnt_q == 4'd0) && conv_done_s) begin
                        bcd1_q <= conv_bcd_s;
                    end else begin
                        bcd1_q <= bcd1_q;
                    end
                    if (cnt_q == 4'd15) begin
                        state_q <= ST_COMMIT;
                    end else begin
                        state_q <= ST_SHIFT2;
                    end
                end
                ST_COMMIT: begin
                    dirty_q <= dirty_q | trigger_s;
                    buf_q   <= render_s;
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    dirty_q <= 1'b1;
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Digit scan: divider, digit index and registered pin values.
    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_BLANK;
            seg_sel_q  <= {{(NUM_DIGITS-1){1'b0}}, 1'b1};
        end else begin
            seg_q     <= buf_q[idx_q];
            seg_sel_q <= {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
            if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                scan_cnt_q <= '0;
                if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                    idx_q <= '0;
                end else begin
                    idx_q <= idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end else begin
                scan_cnt_q <= scan_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign seg     = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign seg_sel = (ACTIVE_LOW != 0) ? ~seg_sel_q : seg_sel_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_out_scan_display.sv
// Directed, table-driven bench for out_scan_display (SCAN_DIV = 4).
module tb_out_scan_display;

    localparam int NS = 8;
    localparam int SW = 3;
    localparam int ND = 8;
    localparam int SD = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [SW-1:0] wr_sel;
    logic [15:0]   wr_val1;
    logic [15:0]   wr_val2;
    logic          wr_dec;
    logic [SW-1:0] page;
    logic [7:0]    seg;
    logic [ND-1:0] seg_sel;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]  slot;
        logic [15:0] v1;
        logic [15:0] v2;
        logic        dec;
        int          busy_len;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    out_scan_display #(
        .NUM_SLOTS(NS), .SEL_W(SW), .NUM_DIGITS(ND), .SCAN_DIV(SD), .ACTIVE_LOW(0)
    ) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_val1(wr_val1), .wr_val2(wr_val2), .wr_dec(wr_dec), .page(page),
        .seg(seg), .seg_sel(seg_sel), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Watch one full scan and assemble the eight digits (digit 7 in the top byte).
    task automatic capture(output logic [63:0] got);
        got = '1;
        repeat (2 * ND * SD + 4) begin
            @(negedge clock);
            for (int d = 0; d < ND; d++) begin
                if (seg_sel == (8'd1 << d)) got[8*d +: 8] = seg;
            end
        end
    endtask

    task automatic do_write(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b,
                            input logic dec, input logic [2:0] pg);
        page = pg; wr_en = 1'b1; wr_sel = s; wr_val1 = a; wr_val2 = b; wr_dec = dec;
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic measure_busy(output int len);
        int w;
        w = 0;
        while (!busy && w < 20) begin w++; @(negedge clock); end
        len = 0;
        while (busy && len < 200) begin len++; @(negedge clock); end
    endtask

    initial begin
        logic [63:0] got;
        logic [63:0] last_exp;
        int len, len1, len2, gap, hits;

        vecs[0] = '{3'd2, 16'h1234, 16'hBEEF, 1'b0, 2,  64'h065B4F66_7C797971};
        vecs[1] = '{3'd1, 16'd42,   16'd9999, 1'b1, 34, 64'h0000665B_6F6F6F6F};
        vecs[2] = '{3'd1, 16'd10000, 16'd0,   1'b1, 34, 64'h40404040_0000003F};
        vecs[3] = '{3'd3, 16'h00A5, 16'h0F00, 1'b0, 2,  64'h3F3F776D_3F713F3F};
        vecs[4] = '{3'd4, 16'd0,    16'd5,    1'b1, 34, 64'h0000003F_0000006D};
        vecs[5] = '{3'd6, 16'd65535, 16'd1234, 1'b1, 34, 64'h40404040_065B4F66};
        vecs[6] = '{3'd0, 16'd9999, 16'd100,  1'b1, 34, 64'h6F6F6F6F_00063F3F};
        vecs[7] = '{3'd1, 16'd1000, 16'd9,    1'b1, 34, 64'h063F3F3F_0000006F};

        reset = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_val1 = '0; wr_val2 = '0;
        wr_dec = 1'b0; page = '0;
        repeat (3) @(negedge clock);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_seg_sel", {56'd0, seg_sel}, 64'd1);
        check("reset_seg", {56'd0, seg}, 64'd0);

        // Scan order after release: one step every SD cycles, wrapping after 8.
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            check($sformatf("scan_k%0d", k), {56'd0, seg_sel},
                  64'd1 << (((k - 1) / SD) % ND));
        end
        capture(got);
        check("reset_digits", got, 64'h3F3F3F3F_3F3F3F3F);

        for (int v = 0; v < 8; v++) begin
            do_write(vecs[v].slot, vecs[v].v1, vecs[v].v2, vecs[v].dec, vecs[v].slot);
            measure_busy(len);
            check($sformatf("vec%0d_busy_len", v), 64'(len), 64'(vecs[v].busy_len));
            capture(got);
            check($sformatf("vec%0d_digits", v), got, vecs[v].exp);
        end
        last_exp = vecs[7].exp;

        // Writing another slot must not disturb the displayed one.
        do_write(3'd5, 16'h5555, 16'h6666, 1'b0, 3'd1);
        hits = 0;
        repeat (10) begin
            @(negedge clock);
            if (busy) hits++;
        end
        check("other_slot_busy", 64'(hits), 64'd0);
        capture(got);
        check("other_slot_digits", got, last_exp);

        // Rewrite of the shown slot mid-conversion: finish, one idle cycle, redo.
        do_write(3'd1, 16'd321, 16'd77, 1'b1, 3'd1);
        gap = 0;
        while (!busy && gap < 20) begin gap++; @(negedge clock); end
        len1 = 0;
        while (busy && len1 < 200) begin
            len1++;
            if (len1 == 10) begin
                wr_en = 1'b1; wr_sel = 3'd1; wr_val1 = 16'd5; wr_val2 = 16'd60000; wr_dec = 1'b1;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clock);
        end
        wr_en = 1'b0;
        check("retrig_first_len", 64'(len1), 64'd34);
        gap = 0;
        while (!busy && gap < 10) begin gap++; @(negedge clock); end
        check("retrig_idle_gap", 64'(gap), 64'd1);
        len2 = 0;
        while (busy && len2 < 200) begin len2++; @(negedge clock); end
        check("retrig_second_len", 64'(len2), 64'd34);
        capture(got);
        check("retrig_digits", got, 64'h0000006D_40404040);

        // Reset during SHIFT2 aborts, blanks, then the zero slot redisplays.
        do_write(3'd1, 16'd4321, 16'd8765, 1'b1, 3'd1);
        gap = 0;
        while (!busy && gap < 20) begin gap++; @(negedge clock); end
        repeat (25) @(negedge clock);
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_busy", {63'd0, busy}, 64'd0);
        check("midreset_seg_sel", {56'd0, seg_sel}, 64'd1);
        check("midreset_seg", {56'd0, seg}, 64'd0);
        reset = 1'b0;
        measure_busy(len);
        check("post_reset_busy_len", 64'(len), 64'd2);
        capture(got);
        check("post_reset_digits", got, 64'h3F3F3F3F_3F3F3F3F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/out_scan_display.md
Name: out_scan_display

Overview:
Parametrised successor to the fixed 8-digit processor output display. It holds NUM_SLOTS (val1, val2) pairs written by the processor through the outsel/outdisplay-style write port, and shows one selected slot on a time-multiplexed 7-segment bank. Each slot renders in hex or unsigned decimal. Decimal conversion uses a sequential double-dabble engine with leading-zero blanking and an overflow indication. The block sits between the processor and the board LED/segment pins.

Parameters:
NUM_SLOTS, 8, number of stored value pairs
SEL_W, 3, slot select width (2**SEL_W >= NUM_SLOTS)
NUM_DIGITS, 8, total digits; even, 4..10; D = NUM_DIGITS/2 digits per value
SCAN_DIV, 4000, clock cycles each digit stays selected (>=2)
ACTIVE_LOW, 0, 1 = invert seg and seg_sel at the pins

Ports:
clock  in  1  single system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  write strobe (outdisplay)
wr_sel  in  SEL_W  slot written (outsel)
wr_val1  in  16  value shown on upper D digits
wr_val2  in  16  value shown on lower D digits
wr_dec  in  1  slot mode: 0 = hex, 1 = unsigned decimal
page  in  SEL_W  slot currently displayed
seg  out  8  segments of the selected digit: bit0=a .. bit6=g, bit7=dp
seg_sel  out  NUM_DIGITS  one-hot digit enable; bit0 = rightmost digit
busy  out  1  conversion in progress

Behaviour:
- Reset, registered on the next edge: all slots 0 in hex mode; scan counter 0; digit index 0; display buffer blank; busy 0; dirty 1. Pins after reset: seg_sel = 1, seg = 0x00, both before ACTIVE_LOW inversion.
- Write: when wr_en is high, slot[wr_sel] takes {val1, val2, dec} at the clock edge. If wr_sel >= NUM_SLOTS the write is ignored.
- Trigger: dirty is set by any of the following: a write whose wr_sel equals page; a change of page from the previous cycle; reset.
- FSM states IDLE, LOAD, SHIFT1, SHIFT2, COMMIT.
  - IDLE: if dirty, clear dirty and go to LOAD.
  - LOAD: snapshot slot[page]. Go to COMMIT if hex mode, else SHIFT1.
  - SHIFT1: 16 cycles of double-dabble on val1.
  - SHIFT2: 16 cycles of double-dabble on val2.
  - COMMIT: write the display buffer, then go to IDLE.
- Latency to buffer update: hex 2 cycles; decimal 34 cycles.
- busy is high in every state except IDLE.
- A trigger arriving while busy sets dirty. The running conversion is not aborted. A new LOAD follows COMMIT, with one IDLE cycle between them. The final buffer always reflects the latest slot contents.
- If page is >= NUM_SLOTS, the buffer is all blank.
- Hex rendering: each half shows the low D nibbles of the value, MS nibble leftmost. No blanking. For D > 4 the upper digits show 0.
- Decimal rendering: the 5 BCD digits are computed.
  - Overflow: if any BCD digit at index >= D is nonzero (value > 10^D - 1), all D digits of that half show a dash (0x40).
  - Otherwise leading zeros are blanked (0x00). The least-significant digit always shows.
- Segment codes, digits 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71. dp is always 0.
- Scan:
  - The counter counts 0..SCAN_DIV-1. On wrap, the digit index increments; it wraps from NUM_DIGITS-1 to 0.
  - seg_sel = 1 << idx. seg = buffer[idx].
  - Both outputs are registered, with 1-cycle latency from idx. They change only on a digit advance or a buffer COMMIT.
  - The scan runs independently of the FSM and of writes.
- Reset mid-conversion: the FSM returns to IDLE, busy = 0 on the next edge, and the buffer is blanked. A conversion of the zero slot starts after reset is released.

Decomposition:
- Package out_display_pkg holds:
  - the segment code table;
  - SEG_BLANK = 8'h00 and SEG_DASH = 8'h40;
  - the FSM state enum;
  - the bcd5 digit-array typedef.
- Sub-module bin_to_bcd_seq: a 16-bit sequential double-dabble converter. Interface: start pulse, 16-cycle run, done, 5 BCD digits out. It is instantiated once and reused for val1 and then val2.

Test Plan:
1. Reset with page=0, SCAN_DIV=4 → within 3 cycles the buffer commits. seg_sel steps 01,02,04 ... 80 then wraps to 01, one step every 4 cycles. seg = 0x3F on every digit.
2. Write slot 2 = {0x1234, 0xBEEF, hex} with page=2 → busy is high for 2 cycles. Digits 7..0 = 06 5B 4F 66 7C 79 79 71.
3. Write slot 1 = {42, 9999, dec}, then page=1 → busy is high for exactly 34 cycles. Digits 7..0 = 00 00 66 5B | 6F 6F 6F 6F.
4. Write slot 1 = {10000, 0, dec} → upper half shows 40 40 40 40. Lower half shows 00 00 00 3F.
5. Write slot 5 while page=1 → busy stays 0 and the display is unchanged. Then write slot 1 during cycle 10 of a conversion → a second LOAD starts 2 cycles after COMMIT, and the final digits match the second write.
6. Assert reset during SHIFT2 → on the next edge busy = 0, seg_sel = 01, seg = 00. After release, digits return to 3F (hex zero).
